tx_gearbox: RTL and testbench
=============================

// Module: tx_gearbox
// PURPOSE
//  Transmit-side 66b->32b gearbox for the 10G PCS.
//  - Input: encoded 66-bit blocks from the 64b/66b encoder/scrambler, presented as two 32-bit
//    half-blocks. The 2-bit sync header rides with the first half.
//  - Output: a continuous 32-bit word stream, bit 0 transmitted first, to the serializer.
//  - Produces the stream that the Rx block-sync recovers. Wire order per block:
//    hdr[0], hdr[1], data_word0[0..31], data_word1[0..31].
// PARAMETERS
//  DATA_WIDTH  32  half-block / output word width (only 32 supported)
//  HDR_WIDTH   2   sync header width (only 2 supported)
// PORTS
//  i_clk      in   1           single clock
//  i_reset_n  in   1           reset; asynchronous assert, active-low
//  i_data     in   DATA_WIDTH  half-block payload (data_word0 on phase 0, data_word1 on phase 1)
//  i_hdr      in   HDR_WIDTH   sync header; sampled only on a phase-0 beat (01=data, 10=ctrl)
//  i_valid    in   1           upstream beat valid
//  o_ready    out  1           gearbox accepts a beat this cycle; beat taken when i_valid&o_ready
//  o_data     out  DATA_WIDTH  gearboxed word, LSB first on the line
//  o_valid    out  1           o_data holds a new word this cycle
// BEHAVIOUR
//  State
//   - buf[63:0]: pending bits, LSB-aligned.
//   - occ[5:0]: pending bit count. Always even, range 0..32.
//   - phase: 0 = expecting first half, 1 = expecting second half. Toggles on every accepted beat.
//  Per cycle
//   - acc = i_valid & o_ready.
//   - vec = phase ? i_data : {i_data, i_hdr}.
//   - n = acc ? (phase ? 32 : 34) : 0.
//   - comb[65:0] = buf | (vec << occ).
//   - avail = occ + n (7-bit, max 64).
//  Registered update
//   - avail >= 32: o_data <= comb[31:0]; o_valid <= 1; buf <= comb >> 32; occ <= avail - 32.
//   - avail < 32: buf <= comb; occ <= avail; o_valid <= 0; o_data holds its value.
//  Ready and throughput
//   - o_ready = (occ != 32). Combinational from a register, no path from i_valid.
//   - Pause: with continuous input, occ rises by 2 per block, so o_ready drops for exactly
//     1 cycle in every 33.
//   - The pause may fall between the two halves of a block. Upstream holds i_data/i_hdr, and
//     phase is not advanced.
//   - In the pause cycle occ = 32: the buffered word is emitted and occ returns to 0.
//  Latency
//   - A beat accepted in cycle t contributes to o_data valid in cycle t+1.
//   - First block after reset: o_valid = 1 from cycle t+1 (avail = 34).
//  Upstream gaps (i_valid = 0)
//   - buf/occ/phase hold; no output unless occ == 32.
//   - o_valid may go low. Upstream must not gap in normal operation; a gap breaks line
//     continuity but corrupts no data.
//  i_hdr
//   - Ignored on phase-1 beats.
//   - Header values 00/11 pass through unchanged; no checking in this block.
//  Reset (any time, including mid-block or in a pause)
//   - buf = 0, occ = 0, phase = 0, o_valid = 0, o_data = 0.
//   - o_ready = 1 from the first cycle after reset release.
// STRUCTURE
//  - Shared package pcs_pkg: DATA_WIDTH, HDR_WIDTH, SYNC_DATA = 2'b01, SYNC_CTRL = 2'b10,
//    encoded_data_t {sync_hdr, data_word[1:0]}. The Tx bench and the Rx block-sync bench
//    both use it.
//  - No sub-module: one always_ff for buf/occ/phase/o_data/o_valid, plus combinational
//    vec/comb/avail/o_ready.
// TESTING
//  1. Reset, then block hdr=01, w0=32'hDEADBEEF, w1=32'h01234567, back-to-back
//     -> o_data = 32'h7AB6FBBD, then 32'h048D159F (low 2 bits = w0[31:30]).
//  2. Continuous random blocks for 330 cycles
//     -> o_ready low exactly at cycles 32, 65, 98, ...; o_valid high every cycle after the
//        first; occ returns to 0 after each pause.
//  3. Pause lands between halves (block 16)
//     -> the held w1 is accepted the next cycle, phase stays 1, and the bitstream is unbroken
//        vs the reference queue.
//  4. i_valid low for 5 cycles mid-stream (occ = 10)
//     -> buf/occ/phase frozen; no o_valid; on resume the stream continues with no lost or
//        duplicated bits.
//  5. Assert i_reset_n = 0 mid-block (phase = 1, occ = 18)
//     -> all outputs 0 and o_ready = 1 right after release; the next block starts with its
//        header at o_data[1:0].
//  6. Loopback: serialize o_data LSB first into the Rx block-sync for 1000 random blocks
//     -> lock achieved; every decoded block matches the reference queue in order.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared PCS definitions: block geometry, sync header codes and the encoded block payload.
package pcs_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned HDR_WIDTH   = 2;
    localparam int unsigned BLOCK_WIDTH = HDR_WIDTH + 2 * DATA_WIDTH;
    localparam int unsigned BUF_WIDTH   = 64;
    localparam int unsigned OCC_WIDTH   = 6;
    localparam int unsigned AVAIL_WIDTH = 7;

    localparam logic [HDR_WIDTH-1:0] SYNC_DATA = 2'b01;
    localparam logic [HDR_WIDTH-1:0] SYNC_CTRL = 2'b10;

    typedef struct packed {
        logic [HDR_WIDTH-1:0]             sync_hdr;
        logic [1:0][DATA_WIDTH-1:0]       data_word;
    } encoded_data_t;

endpackage

// File: rtl/tx_gearbox.sv
// Transmit 66b->32b gearbox: packs header + two half-blocks into a continuous LSB-first word stream.
module tx_gearbox
    import pcs_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [HDR_WIDTH-1:0]  i_hdr,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    localparam int unsigned VEC_WIDTH  = DATA_WIDTH + HDR_WIDTH;
    localparam int unsigned COMB_WIDTH = BUF_WIDTH + HDR_WIDTH;

    logic [BUF_WIDTH-1:0]   pend_q, pend_d;
    logic [OCC_WIDTH-1:0]   occ_q, occ_d;
    logic                   phase_q, phase_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   valid_q, valid_d;

    logic                   acc;
    logic [VEC_WIDTH-1:0]   vec;
    logic [AVAIL_WIDTH-1:0] n_bits;
    logic [AVAIL_WIDTH-1:0] avail;
    logic [COMB_WIDTH-1:0]  comb;

    // A full 32-bit backlog forces one cycle of drain with no intake.
    assign o_ready = (occ_q != OCC_WIDTH'(DATA_WIDTH));
    assign acc     = i_valid & o_ready;

    assign o_data  = data_q;
    assign o_valid = valid_q;

    // Merge the accepted beat above the pending bits and emit a word once 32 bits are available.
    always_comb begin
        vec     = '0;
        n_bits  = '0;
        pend_d  = pend_q;
        occ_d   = occ_q;
        phase_d = phase_q ^ acc;
        data_d  = data_q;
        valid_d = 1'b0;

        // Unaccepted input must not leak into the pending buffer above occ.
        if (acc) begin
            vec    = phase_q ? VEC_WIDTH'(i_data) : {i_data, i_hdr};
            n_bits = phase_q ? AVAIL_WIDTH'(DATA_WIDTH) : AVAIL_WIDTH'(VEC_WIDTH);
        end

        comb  = COMB_WIDTH'(pend_q) | (COMB_WIDTH'(vec) << occ_q);
        avail = AVAIL_WIDTH'(occ_q) + n_bits;

        if (avail >= AVAIL_WIDTH'(DATA_WIDTH)) begin
            data_d  = comb[DATA_WIDTH-1:0];
            valid_d = 1'b1;
            pend_d  = BUF_WIDTH'(comb >> DATA_WIDTH);
            occ_d   = OCC_WIDTH'(avail - AVAIL_WIDTH'(DATA_WIDTH));
        end else begin
            pend_d  = comb[BUF_WIDTH-1:0];
            occ_d   = OCC_WIDTH'(avail);
        end
    end

    // Gearbox state and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pend_q  <= '0;
            occ_q   <= '0;
            phase_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            occ_q   <= occ_d;
            phase_q <= phase_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_tx_gearbox.sv
// Bench for tx_gearbox: bit-queue reference model with a scoreboard monitor on the output words.
module tb_tx_gearbox;
    import pcs_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [DATA_WIDTH-1:0] i_data = '0;
    logic [HDR_WIDTH-1:0]  i_hdr = '0;
    logic                  i_valid = 1'b0;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Line bits not yet seen on o_data, in wire order.
    bit bitq[$];
    bit in_reset = 1'b1;

    // Upstream source state: the block being offered and which half is presented.
    logic [HDR_WIDTH-1:0]  cur_hdr;
    logic [DATA_WIDTH-1:0] cur_w0;
    logic [DATA_WIDTH-1:0] cur_w1;
    bit                    cur_half;

    tx_gearbox dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_data    (i_data),
        .i_hdr     (i_hdr),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_valid   (o_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic new_block();
        if ($urandom_range(0, 9) == 0)
            cur_hdr = 2'($urandom_range(0, 3));
        else
            cur_hdr = ($urandom_range(0, 1) == 1) ? SYNC_DATA : SYNC_CTRL;
        cur_w0 = $urandom;
        cur_w1 = $urandom;
    endtask

    // Present the current half; if the gearbox takes it at the next edge, record its bits.
    task automatic beat(input bit v);
        i_valid = v;
        i_data  = cur_half ? cur_w1 : cur_w0;
        i_hdr   = cur_half ? 2'($urandom_range(0, 3)) : cur_hdr;
        if (v && o_ready) begin
            if (!cur_half) begin
                bitq.push_back(cur_hdr[0]);
                bitq.push_back(cur_hdr[1]);
                for (int i = 0; i < 32; i++) bitq.push_back(cur_w0[i]);
            end else begin
                for (int i = 0; i < 32; i++) bitq.push_back(cur_w1[i]);
                new_block();
            end
            cur_half = ~cur_half;
        end
    endtask

    // Called at a negedge: reset for two cycles, release, check the idle state.
    task automatic do_reset();
        rst_n    = 1'b0;
        in_reset = 1'b1;
        i_valid  = 1'b0;
        bitq.delete();
        cur_half = 1'b0;
        new_block();
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        in_reset = 1'b0;
        #1;
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_data",  o_data,       32'd0);
        check("rst_o_ready", 32'(o_ready), 32'd1);
    endtask

    // Scoreboard monitor: a word must appear exactly when 32 line bits are owed.
    always @(posedge clk) begin
        logic [31:0] w;
        #1;
        if (!in_reset) begin
            check("o_valid", 32'(o_valid), 32'(bitq.size() >= 32));
            if (o_valid && bitq.size() >= 32) begin
                for (int i = 0; i < 32; i++) w[i] = bitq.pop_front();
                check("o_data", o_data, w);
            end
            check("o_ready", 32'(o_ready), 32'(bitq.size() != 32));
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [HDR_WIDTH-1:0] h;
        new_block();
        repeat (3) @(negedge clk);
        check("inreset_o_valid", 32'(o_valid), 32'd0);
        check("inreset_o_ready", 32'(o_ready), 32'd1);
        rst_n    = 1'b1;
        in_reset = 1'b0;

        // Known block: header 01 then two fixed half-blocks.
        cur_hdr = SYNC_DATA; cur_w0 = 32'hDEADBEEF; cur_w1 = 32'h01234567; cur_half = 1'b0;
        @(negedge clk); beat(1'b1);
        @(posedge clk); #2;
        check("known_word0", o_data, 32'h7AB6FBBD);
        @(negedge clk); beat(1'b1);
        @(posedge clk); #2;
        check("known_word1", o_data, 32'h048D159F);

        // Continuous stream from reset: one pause every 33 cycles, landing between halves.
        @(negedge clk); do_reset();
        for (int c = 0; c < 330; c++) begin
            @(negedge clk);
            if (c >= 1) check("cont_valid", 32'(o_valid), 32'd1);
            check("cont_ready", 32'(o_ready), 32'((c % 33) != 31));
            if ((c % 33) == 31) check("pause_phase", 32'(dut.phase_q), 32'd1);
            if ((c % 33) == 32) begin
                check("post_pause_occ",   32'(dut.occ_q),   32'd0);
                check("post_pause_phase", 32'(dut.phase_q), 32'd1);
            end
            beat(1'b1);
        end

        // Upstream gap with 10 bits pending.
        @(negedge clk); do_reset();
        for (int b = 0; b < 10; b++) begin
            @(negedge clk); beat(1'b1);
        end
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            if (g >= 1) check("gap_no_valid", 32'(o_valid), 32'd0);
            check("gap_occ",   32'(dut.occ_q),   32'd10);
            check("gap_phase", 32'(dut.phase_q), 32'd0);
            beat(1'b0);
        end
        for (int b = 0; b < 40; b++) begin
            @(negedge clk); beat(1'b1);
        end

        // Reset mid-block with the second half pending.
        @(negedge clk); do_reset();
        for (int b = 0; b < 17; b++) begin
            @(negedge clk); beat(1'b1);
        end
        @(negedge clk);
        check("midblk_occ",   32'(dut.occ_q),   32'd18);
        check("midblk_phase", 32'(dut.phase_q), 32'd1);
        do_reset();
        h = cur_hdr;
        @(negedge clk); beat(1'b1);
        @(posedge clk); #2;
        check("post_rst_hdr", 32'(o_data[1:0]), 32'(h));
        for (int b = 0; b < 20; b++) begin
            @(negedge clk); beat(1'b1);
        end

        // Long random run with occasional upstream gaps.
        @(negedge clk); do_reset();
        for (int c = 0; c < 2200; c++) begin
            @(negedge clk); beat($urandom_range(0, 19) != 0);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); beat(1'b0);
        end
        check("drain_occ", 32'(dut.occ_q), 32'(bitq.size()));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
